// File: rtl/scan_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : scan_sequencer
// Description : Slot sequencer feeding a 2-to-4 decoder. Steps sel through
//               0..3 with a programmable dwell of div+1 cycles per slot, in
//               one-shot or continuous mode. Optional macro SCAN_BLANK_EN
//               inserts one en=0 blanking cycle between consecutive slots.
// Revision    : 1.0 - initial release
//==============================================================================
module scan_sequencer #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [1:0]           sel,
    output logic                 en,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DIV_WIDTH-1:0] c_cnt_one = DIV_WIDTH'(1);
    localparam logic [1:0]           c_sel_one = 2'd1;
    localparam logic [1:0]           c_sel_last = 2'd3;

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1
    } state_t;
`endif

    state_t               r_state, w_state;
    logic [DIV_WIDTH-1:0] r_cnt,   w_cnt;
    logic [DIV_WIDTH-1:0] r_div,   w_div;
    logic                 r_mode,  w_mode;
    logic [1:0]           r_sel,   w_sel;
    logic                 r_en,    w_en;
    logic                 r_busy,  w_busy;
    logic                 r_done,  w_done;

    // State, dwell counter, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_mode  <= 1'b0;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_mode  <= w_mode;
            r_sel   <= w_sel;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Next-state and next-output computation; stop outranks slot progress.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_div   = r_div;
        w_mode  = r_mode;
        w_sel   = r_sel;
        w_en    = r_en;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sel  = 2'd0;
                w_en   = 1'b0;
                w_busy = 1'b0;
                w_cnt  = '0;
                // start together with stop is treated as no request
                if (start && !stop) begin
                    w_state = S_SCAN;
                    w_mode  = mode;
                    w_div   = div;
                    w_en    = 1'b1;
                    w_busy  = 1'b1;
                end
            end

            S_SCAN: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_sel   = 2'd0;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                end else if (r_cnt == r_div) begin
                    w_cnt = '0;
                    if ((r_sel == c_sel_last) && !r_mode) begin
                        // normal end of a one-shot sweep
                        w_state = S_IDLE;
                        w_sel   = 2'd0;
                        w_en    = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
`ifdef SCAN_BLANK_EN
                        // hold sel, drop en for one anti-ghosting cycle
                        w_state = S_BLANK;
                        w_en    = 1'b0;
`else
                        w_sel = r_sel + c_sel_one;
`endif
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end

`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_sel   = 2'd0;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                end else begin
                    w_state = S_SCAN;
                    w_sel   = r_sel + c_sel_one;
                    w_en    = 1'b1;
                end
            end
`endif

            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_sel   = 2'd0;
                w_en    = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
